// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register chain: the bubble encoding and
// the width helper used to size the occupancy count.
package pipe_pkg;

  // A bubble is all-zero data. Downstream logic decodes all-zero as a NOP.
  localparam logic BUBBLE = 1'b0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned bits;
    int unsigned span;
    bits = 0;
    span = 1;
    while (span < n) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake and data bundle for pipe_stage_chain. The master drives the input
// item and the stall/flush controls. The slave is the chain itself.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  import pipe_pkg::*;

  localparam int CW = clog2(DEPTH + 1);

  logic             flush;
  logic             hold;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_accept;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    occupancy;

  modport master (
    output flush, hold, in_valid, in_data,
    input  in_accept, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, hold, in_valid, in_data,
    output in_accept, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage.sv
// One register stage of the chain: a valid bit and a data word. It loads on
// go_i, clears on flush_i, and never holds stale data behind a cleared valid.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = {WIDTH{BUBBLE}};
    end else if (go_i) begin
      valid_d = valid_i;
      data_d  = valid_i ? data_i : {WIDTH{BUBBLE}};
    end
  end

  // NOTE: data is reset along with valid because a bubble must read as all-zero from the first cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      valid_q <= 1'b0;
      data_q  <= {WIDTH{BUBBLE}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep register chain with per-stage valid, stall, single-cycle flush and
// occupancy. Defining PIPE_BUBBLE_COLLAPSE_EN lets items advance into bubbles under hold.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  pipe_stage_chain_if.slave bus
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] go;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];

  logic [CW-1:0] occupancy_q, occupancy_d;

  // The advance chain is computed from the output side back toward the input.
  always_comb begin
    logic ahead;
    go = '0;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    ahead = !bus.hold || !v[DEPTH-1];
    go[DEPTH-1] = ahead;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      ahead = ahead || !v[k];
      go[k] = ahead;
    end
`else
    ahead = !bus.hold;
    go    = {DEPTH{ahead}};
`endif
  end

  assign bus.in_accept = go[0] && !bus.flush;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign up_v[k] = bus.in_valid;
        assign up_d[k] = bus.in_data;
      end else begin : g_body
        assign up_v[k] = v[k-1];
        assign up_d[k] = d[k-1];
      end

      pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clock   (clock),
        .reset   (reset),
        .go_i    (go[k]),
        .flush_i (bus.flush),
        .valid_i (up_v[k]),
        .data_i  (up_d[k]),
        .valid_o (v[k]),
        .data_o  (d[k])
      );
    end
  endgenerate

  // Occupancy tracks the valid bits the stages will hold after this edge.
  always_comb begin
    v_next      = '0;
    occupancy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush)  v_next[i] = 1'b0;
      else if (go[i]) v_next[i] = up_v[i];
      else            v_next[i] = v[i];
      if (v_next[i]) occupancy_d = occupancy_d + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) occupancy_q <= '0;
    else        occupancy_q <= occupancy_d;
  end

  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: items are tracked by stage position and
// compared at the output; honours PIPE_BUBBLE_COLLAPSE_EN like the design.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_stage_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  item_t model[$];
  logic  exp_accept = 1'b0;
  int    n_checks   = 0;
  int    n_fail     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs mid-cycle, then moves the modelled items for the coming edge.
  always @(negedge clock) begin : monitor
    logic             exp_ov;
    logic [WIDTH-1:0] exp_od;
    logic [DEPTH-1:0] occ_map;
    logic             gap;
    item_t            it;
    item_t            tmp[$];
    if (!reset) begin
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_out_data", 64'(bus.out_data), 64'd0);
      check("reset_occupancy", 64'(bus.occupancy), 64'd0);
      model.delete();
      exp_accept = 1'b0;
    end else begin
      exp_ov = (model.size() > 0) && (model[0].pos == DEPTH - 1);
      exp_od = exp_ov ? model[0].data : '0;
      exp_accept = !bus.flush && (!bus.hold || (COLLAPSE && model.size() < DEPTH));
      check("occupancy", 64'(bus.occupancy), 64'(model.size()));
      check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      check("out_data", 64'(bus.out_data), 64'(exp_od));
      check("in_accept", 64'(bus.in_accept), 64'(exp_accept));
      if (bus.flush) begin
        model.delete();
      end else begin
        occ_map = '0;
        foreach (model[i]) occ_map[model[i].pos] = 1'b1;
        tmp.delete();
        foreach (model[i]) begin
          it = model[i];
          if (it.pos == DEPTH - 1) begin
            if (bus.hold) tmp.push_back(it);
          end else begin
            gap = 1'b0;
            for (int j = it.pos + 1; j < DEPTH; j++) if (!occ_map[j]) gap = 1'b1;
            if (!bus.hold || (COLLAPSE && gap)) it.pos++;
            tmp.push_back(it);
          end
        end
        model = tmp;
      end
    end
  end

  // One clock of stimulus; an item the chain will accept is queued as expected output.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic h, input logic f);
    item_t it;
    @(posedge clock);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.hold     = h;
    bus.flush    = f;
    @(negedge clock);
    #1;
    if (reset && exp_accept && v) begin
      it.data = d;
      it.pos  = 0;
      model.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Streaming at full rate.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    idle(DEPTH + 2);

    // Stall with a full chain, with an input offered during the stall.
    cycle(1'b1, 32'hAA, 1'b0, 1'b0);
    cycle(1'b1, 32'hBB, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'hCC, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(DEPTH + 2);

    // Flush while full and stalled, with an input on the flush cycle.
    cycle(1'b1, 32'h01, 1'b0, 1'b0);
    cycle(1'b1, 32'h02, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h99, 1'b1, 1'b1);
    cycle(1'b1, 32'h03, 1'b0, 1'b0);
    idle(DEPTH + 2);

    // Single item followed by a bubble, then hold.
    cycle(1'b1, 32'h05, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h07, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(DEPTH + 2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
            $urandom_range(0, 19) == 0);
    end
    idle(DEPTH + 3);

    check("drain_occupancy", 64'(bus.occupancy), 64'd0);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
